// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle core for the 16-bit ISA with one shared req/ack memory port.
// Optional misaligned JAL/LDW/STW trap is enabled by defining CPU_MISALIGN_TRAP_EN.
module cpu_multicycle #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              retire,
    output logic              halted,
    output logic              trap,
    output logic [3:0]        flags,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [15:0]       dbg_ir
);
    localparam int SW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

`ifdef CPU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_ORR = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_LSL = 4'h6;
    localparam logic [3:0] OP_LSR = 4'h7;
    localparam logic [3:0] OP_ADI = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_LDW = 4'hA;
    localparam logic [3:0] OP_STW = 4'hB;
    localparam logic [3:0] OP_BRZ = 4'hC;
    localparam logic [3:0] OP_JAL = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hE;
    localparam logic [3:0] OP_NOP = 4'hF;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] maddr;
    logic [15:0]       ir;
    logic [WIDTH-1:0]  regs [16];
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  d;
    logic [WIDTH-1:0]  res;
    logic [3:0]        flags_q;
    logic              trap_q;

    logic [3:0]        op;
    logic [3:0]        rd;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [WIDTH-1:0]  imm;
    logic [ADDR_W-1:0] pc2;
    logic [ADDR_W-1:0] boff;
    logic [WIDTH-1:0]  ea_w;
    logic [ADDR_W-1:0] ea;
    logic              mis_mem;
    logic              mis_jal;

    assign op   = ir[15:12];
    assign rd   = ir[11:8];
    assign rs   = ir[7:4];
    assign rt   = ir[3:0];
    assign imm  = {{(WIDTH-8){ir[7]}}, ir[7:0]};
    assign pc2  = pc + ADDR_W'(2);
    assign boff = {{(ADDR_W-9){ir[7]}}, ir[7:0], 1'b0};
    assign ea_w = a + b;
    assign ea   = ea_w[ADDR_W-1:0];

    assign mis_mem = TRAP_EN && ea[0];
    assign mis_jal = TRAP_EN && a[0];

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH:0]   adi_s;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
    logic             upd;

    // Carry for SUB is the inverted borrow, taken from a + ~b + 1.
    always_comb begin
        add_s = {1'b0, a} + {1'b0, b};
        sub_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        adi_s = {1'b0, d} + {1'b0, imm};
        y     = '0;
        c     = 1'b0;
        v     = 1'b0;
        upd   = 1'b1;
        case (op)
            OP_ADD: begin
                y = add_s[M:0];
                c = add_s[WIDTH];
                v = (a[M] == b[M]) && (y[M] != a[M]);
            end
            OP_SUB: begin
                y = sub_s[M:0];
                c = sub_s[WIDTH];
                v = (a[M] != b[M]) && (y[M] != a[M]);
            end
            OP_AND: y = a & b;
            OP_ORR: y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_LSL: y = a << b[SW-1:0];
            OP_LSR: y = a >> b[SW-1:0];
            OP_ADI: begin
                y = adi_s[M:0];
                c = adi_s[WIDTH];
                v = (d[M] == imm[M]) && (y[M] != d[M]);
            end
            OP_LDI: begin
                y   = imm;
                upd = 1'b0;
            end
            default: upd = 1'b0;
        endcase
    end

    logic             rf_we;
    logic [WIDTH-1:0] rf_wd;

    always_comb begin
        rf_we = 1'b0;
        rf_wd = res;
        if (state == S_WB) begin
            rf_we = 1'b1;
        end else if (state == S_EXEC && op == OP_JAL && !mis_jal) begin
            rf_we = 1'b1;
            rf_wd = WIDTH'(pc2);
        end
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            S_WB:   retire = 1'b1;
            S_EXEC: retire = (op == OP_BRZ) || (op == OP_NOP) || (op == OP_HLT)
                             || (op == OP_JAL && !mis_jal);
            S_MEM:  retire = (op == OP_STW) && mem_ack;
            default: retire = 1'b0;
        endcase
    end

    // Gating with rst drops the request combinationally while reset is held.
    assign mem_req   = rst && (state == S_FETCH || state == S_MEM);
    assign mem_we    = (state == S_MEM) && (op == OP_STW);
    assign mem_addr  = !rst ? '0
                     : (state == S_FETCH) ? pc
                     : (state == S_MEM) ? maddr : '0;
    assign mem_wdata = (state == S_MEM && op == OP_STW) ? d : '0;

    assign halted = (state == S_HALT);
    assign trap   = TRAP_EN && trap_q;
    assign flags  = flags_q;
    assign dbg_pc = pc;
    assign dbg_ir = ir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            pc      <= ADDR_W'(RESET_PC);
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            d       <= '0;
            res     <= '0;
            maddr   <= '0;
            flags_q <= '0;
            trap_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (rf_we && rd != 4'd0) begin
                regs[rd] <= rf_wd;
            end
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata[15:0];
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= regs[rs];
                    b     <= regs[rt];
                    d     <= regs[rd];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (upd) begin
                        flags_q <= {v, y[M], c, y == '0};
                    end
                    case (op)
                        OP_LDW, OP_STW: begin
                            if (mis_mem) begin
                                trap_q <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                maddr <= {ea[ADDR_W-1:1], 1'b0};
                                state <= S_MEM;
                            end
                        end
                        OP_BRZ: begin
                            pc    <= (d == '0) ? pc2 + boff : pc2;
                            state <= S_FETCH;
                        end
                        OP_JAL: begin
                            if (mis_jal) begin
                                trap_q <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                pc    <= {a[ADDR_W-1:1], 1'b0};
                                state <= S_FETCH;
                            end
                        end
                        OP_HLT: state <= S_HALT;
                        OP_NOP: begin
                            pc    <= pc2;
                            state <= S_FETCH;
                        end
                        default: begin
                            res   <= y;
                            state <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op == OP_LDW) begin
                            res   <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            pc    <= pc2;
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    pc    <= pc2;
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: program-level checks of cpu_multicycle against hand-computed results.
// Memory model: program ROM outside 0x40..0x7F, data RAM inside, ack after lat wait cycles.
module tb_cpu_multicycle;
    localparam logic [15:0] H = 16'hE000;
`ifdef CPU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        retire;
    logic        halted;
    logic        trap;
    logic [3:0]  flags;
    logic [15:0] dbg_pc;
    logic [15:0] dbg_ir;

    cpu_multicycle #(.WIDTH(16), .ADDR_W(16), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .retire(retire), .halted(halted), .trap(trap), .flags(flags),
        .dbg_pc(dbg_pc), .dbg_ir(dbg_ir)
    );

    always #5 clk = ~clk;

    logic [15:0] prog [0:255];
    logic [15:0] dmem [0:31];
    int          lat = 0;
    logic        ack_force = 1'b0;
    int          cnt;
    logic        in_d;

    assign in_d      = (mem_addr[15:6] == 10'd1);
    assign mem_ack   = ack_force | (mem_req && (cnt >= lat));
    assign mem_rdata = in_d ? dmem[mem_addr[5:1]] : prog[mem_addr[8:1]];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) cnt <= 0;
        else cnt <= cnt + 1;
        if (mem_req && mem_ack && mem_we && in_d) dmem[mem_addr[5:1]] <= mem_wdata;
    end

    int ncyc;
    always @(posedge clk) begin
        if (!rst) ncyc <= 0;
        else ncyc <= ncyc + 1;
    end

    int          retq[$];
    logic [15:0] fetchq[$];
    int          xlen;
    logic [15:0] xaddr;
    int          unstable;
    int          badlen;

    always @(negedge clk) begin
        if (!rst) begin
            retq.delete();
            fetchq.delete();
            xlen = 0;
            unstable = 0;
            badlen = 0;
        end else begin
            if (retire) retq.push_back(ncyc + 1);
            if (mem_req) begin
                if (xlen == 0) xaddr = mem_addr;
                else if (mem_addr != xaddr) unstable++;
                xlen++;
                if (mem_ack) begin
                    if (lat > 0 && xlen != lat + 1) badlen++;
                    xlen = 0;
                    if (!mem_we && !in_d) fetchq.push_back(mem_addr);
                end
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    typedef struct {
        string        name;
        logic [191:0] prog;
        int           lat;
        logic [15:0]  a1;
        logic [15:0]  e1;
        logic [15:0]  a2;
        logic [15:0]  e2;
        logic [3:0]   ef;
        int           ecyc;
        int           eret;
        int           r3;
    } vec_t;

    function automatic logic [191:0] p12(
        input logic [15:0] w0, w1, w2, w3, w4, w5,
        input logic [15:0] w6, w7, w8, w9, w10, w11);
        return {w11, w10, w9, w8, w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic load(input logic [191:0] p);
        for (int j = 0; j < 256; j++) prog[j] = H;
        for (int j = 0; j < 12; j++) prog[j] = p[j*16 +: 16];
    endtask

    task automatic reset_cpu();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_to_halt(input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    vec_t vecs[7];
    int   n;

    initial begin
        vecs[0] = '{"addflags", p12(16'h9105, 16'h92FD, 16'h0312, 16'h9740, 16'hB370,
                    16'h9642, 16'hB160, H, H, H, H, H), 0,
                    16'h40, 16'h0002, 16'h42, 16'h0005, 4'b0010, 31, 8, 12};
        vecs[1] = '{"adisub", p12(16'h917F, 16'h8101, 16'h1201, 16'h9740, 16'hB270,
                    16'h9642, 16'hB160, H, H, H, H, H), 0,
                    16'h40, 16'hFF80, 16'h42, 16'h0080, 4'b0100, 31, 8, 12};
        vecs[2] = '{"slowmem", p12(16'h915A, 16'h9740, 16'hB170, 16'hA470, 16'h9642,
                    16'hB460, H, H, H, H, H, H), 2,
                    16'h40, 16'h005A, 16'h42, 16'h005A, 4'b0000, 48, 7, 20};
        vecs[3] = '{"branch", p12(16'h9101, 16'hC102, 16'hC001, 16'h9211, 16'h9740,
                    16'hB270, 16'h9642, 16'hB960, H, H, H, H), 0,
                    16'h40, 16'h0000, 16'h42, 16'h0000, 4'b0000, 29, 8, 10};
        vecs[4] = '{"logic", p12(16'h910F, 16'h92F0, 16'h3412, 16'h2312, 16'h9740,
                    16'hB470, 16'h9642, 16'hB360, H, H, H, H), 0,
                    16'h40, 16'hFFFF, 16'h42, 16'h0000, 4'b0001, 35, 9, 12};
        vecs[5] = '{"shift", p12(16'h9103, 16'h9204, 16'h6312, 16'h92FF, 16'h7421,
                    16'h9740, 16'hB370, 16'h9642, 16'hB460, H, H, H), 0,
                    16'h40, 16'h0030, 16'h42, 16'h1FFF, 4'b0000, 39, 10, 12};
        vecs[6] = '{"overflow", p12(16'h9101, 16'h920F, 16'h6312, 16'h1431, 16'h9740,
                    16'hB470, 16'h9642, 16'hB360, H, H, H, H), 0,
                    16'h40, 16'h7FFF, 16'h42, 16'h8000, 4'b1010, 35, 9, 12};

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].prog);
            lat = vecs[i].lat;
            reset_cpu();
            run_to_halt(500, n);
            check({vecs[i].name, " halted"}, halted, 1);
            check({vecs[i].name, " cycles"}, n, vecs[i].ecyc);
            check({vecs[i].name, " flags"}, flags, vecs[i].ef);
            check({vecs[i].name, " mem1"}, dmem[vecs[i].a1[5:1]], vecs[i].e1);
            check({vecs[i].name, " mem2"}, dmem[vecs[i].a2[5:1]], vecs[i].e2);
            check({vecs[i].name, " retires"}, retq.size(), vecs[i].eret);
            check({vecs[i].name, " retire3"}, retq[2], vecs[i].r3);
            check({vecs[i].name, " addr_stable"}, unstable, 0);
            check({vecs[i].name, " req_len"}, badlen, 0);
            check({vecs[i].name, " trap"}, trap, 0);
        end

        // BRZ r0,-2 after a NOP: fetch bounces between 0 and 2
        load(p12(16'hF000, 16'hC0FE, H, H, H, H, H, H, H, H, H, H));
        lat = 0;
        reset_cpu();
        repeat (20) @(negedge clk);
        check("brz_loop halted", halted, 0);
        check("brz_loop f0", fetchq[0], 16'h0000);
        check("brz_loop f1", fetchq[1], 16'h0002);
        check("brz_loop f2", fetchq[2], 16'h0000);
        check("brz_loop f3", fetchq[3], 16'h0002);
        check("brz_loop f4", fetchq[4], 16'h0000);

        // JAL r5,r6 at 0x20 with r6=0x100
        load(p12(16'h9533, 16'h9601, 16'h9808, 16'h6668, 16'hF000, 16'hF000,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000));
        for (int j = 12; j < 16; j++) prog[j] = 16'hF000;
        prog[16]   = 16'hD560;
        prog[128]  = 16'h9740;
        prog[129]  = 16'hB570;
        prog[130]  = H;
        reset_cpu();
        run_to_halt(500, n);
        check("jal halted", halted, 1);
        check("jal link", dmem[0], 16'h0022);
        check("jal pc", dbg_pc, 16'h0104);
        check("jal trap", trap, 0);

        // JAL to 0x101
        prog[4]   = 16'h8601;
        prog[128] = 16'h9742;
        reset_cpu();
        run_to_halt(500, n);
        check("jal_odd halted", halted, 1);
        check("jal_odd trap", trap, TRAP);
        check("jal_odd pc", dbg_pc, TRAP ? 16'h0020 : 16'h0104);
        check("jal_odd mem", dmem[1], TRAP ? 16'h8000 : 16'h0022);

        // Reset while a fetch is waiting for ack
        load(vecs[0].prog);
        lat = 0;
        reset_cpu();
        repeat (13) @(negedge clk);
        lat = 20;
        for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("rst pre req", mem_req, 1);
        check("rst pre flags", flags, 4'b0010);
        #2;
        rst = 1'b0;
        #1;
        check("rst req", mem_req, 0);
        check("rst we", mem_we, 0);
        check("rst addr", mem_addr, 0);
        check("rst wdata", mem_wdata, 0);
        check("rst pc", dbg_pc, 0);
        check("rst ir", dbg_ir, 0);
        check("rst flags", flags, 0);
        check("rst retire", retire, 0);
        check("rst halted", halted, 0);
        check("rst trap", trap, 0);
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        check("rst ack pc", dbg_pc, 0);
        check("rst ack ir", dbg_ir, 0);
        check("rst ack req", mem_req, 0);
        ack_force = 1'b0;
        lat = 0;
        rst = 1'b1;
        run_to_halt(500, n);
        check("rerun cycles", n, 31);
        check("rerun fetch0", fetchq[0], 16'h0000);
        check("rerun mem", dmem[0], 16'h0002);
        check("rerun retire1", retq[0], 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor to the single-cycle 16-bit core.
- Executes the fixed 16-bit instruction set with a configurable data width, using an FSM that sequences fetch, decode, execute, memory and writeback.
- Instruction fetch and data accesses share one external memory port with a req/ack handshake, so ROM/RAM latency may vary.
- Sits at the top of the design, above the memory/bus model.

Parameters:
- WIDTH, 16, data/register width in bits; legal range 16..64.
- ADDR_W, 16, memory address width; WIDTH >= ADDR_W.
- RESET_PC, 0, PC value loaded on reset; must be even.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mem_req  out  1  memory request; held high until acknowledged.
- mem_we  out  1  1 = write (STW); 0 = read.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  read data; bits [15:0] carry the instruction during fetch.
- mem_ack  in  1  transfer completes in any cycle where mem_req and mem_ack are both 1.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  core is in HALT.
- trap  out  1  misalignment trap taken (see Optional Feature).
- flags  out  4  {V,N,C,Z} from the last ADD/SUB/logic op.
- dbg_pc  out  ADDR_W  current PC.
- dbg_ir  out  16  instruction register.

Behaviour:
- Instruction fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm8=[7:0]. "sext" means sign extension of imm8 to WIDTH.
- r0 always reads 0; writes to r0 are discarded. 16 registers, each WIDTH wide.
- Opcodes:
  - 0 ADD: rd=rs+rt
  - 1 SUB: rd=rs-rt
  - 2 AND
  - 3 ORR
  - 4 XOR
  - 5 NOT: rd=~rs
  - 6 LSL: rd=rs<<rt[log2(WIDTH)-1:0]
  - 7 LSR: logical shift right, same shift amount
  - 8 ADI: rd=rd+sext(imm8)
  - 9 LDI: rd=sext(imm8)
  - A LDW: rd=mem[rs+rt]
  - B STW: mem[rs+rt]=rd
  - C BRZ: if rd==0, pc=pc+2+(sext(imm8)<<1)
  - D JAL: rd=pc+2; pc=rs (old rs value is used when rd==rs)
  - E HLT
  - F NOP
- Arithmetic is modulo 2^WIDTH. Addresses are the low ADDR_W bits of the result. PC wraps modulo 2^ADDR_W.
- Flags: Z, N and C/V update on ops 0-8 only.
  - Z = result==0; N = result MSB.
  - C = carry out (ADD/ADI) or NOT borrow (SUB). V = signed overflow.
  - Logic ops and shifts clear C and V.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack, latch ir from mem_rdata[15:0] and go to DECODE.
  - DECODE: register read, then EXEC.
  - EXEC: ALU operation or address computation.
    - A/B go to MEM.
    - C/D update the PC and write the link (D), assert retire, go to FETCH.
    - E goes to HALT with retire asserted.
    - F asserts retire, pc+=2, goes to FETCH.
    - Others go to WB.
  - MEM: mem_req=1 with stable addr/we/wdata until ack. Load data is latched on ack. LDW goes to WB; STW asserts retire, pc+=2, goes to FETCH.
  - WB: register write, pc+=2, retire, then FETCH.
  - HALT: absorbing; exited only by reset.
- Cycle counts with mem_ack tied high:
  - ALU/ADI/LDI: 4 cycles.
  - LDW: 5 cycles.
  - STW: 4 cycles.
  - BRZ/JAL/NOP/HLT: 3 cycles.
  - Each wait cycle on mem_ack adds exactly one cycle.
- mem_req is deasserted in the cycle after the ack. It is never asserted outside FETCH/MEM.
- Reset (rst=0), applied at any time including mid-handshake:
  - Immediately: mem_req=0, mem_we=0.
  - State=FETCH, pc=RESET_PC, ir=0, all registers 0.
  - flags=0, retire=0, halted=0, trap=0, mem_addr=0, mem_wdata=0.
  - A pending ack after reset is ignored.
  - The first fetch starts on the first rising edge after rst returns to 1.

Optional Feature:
- Macro: CPU_MISALIGN_TRAP_EN.
- Defined:
  - A JAL target, or an LDW/STW address, with bit0=1 makes the core enter HALT with trap=1.
  - No memory access or register write occurs; the JAL link is not written.
  - retire is not asserted.
- Undefined:
  - Bit0 of such addresses is forced to 0 and execution continues.
  - trap is tied to 0.

Test Plan:
- LDI r1,5; LDI r2,-3; ADD r3,r1,r2 with ack tied high -> r3=2, flags C=1, Z=0, N=0; retire pulses at cycles 4, 8 and 12 after reset release.
- LDI r1,0x7F; ADI r1,1 with WIDTH=16 -> r1=0x0080. Then SUB r2,r0,r1 -> r2=0xFF80, N=1, C=0.
- Memory with a 3-cycle ack delay; STW r1 to address 0x40, then LDW r4 from 0x40 -> mem_req stays high 3 cycles per access with stable address; r4==r1.
- BRZ r0 with imm8=-2 -> pc loops back by 2 instructions. JAL r5,r6 with r6=0x100 at pc=0x20 -> r5=0x22, pc=0x100.
- Pulse rst low while mem_req is high waiting for ack -> mem_req drops asynchronously. After release, fetch starts at RESET_PC and the stale ack is ignored.
- With CPU_MISALIGN_TRAP_EN defined: JAL to 0x101 -> halted=1, trap=1, link register unchanged. Without the macro: pc becomes 0x100.
